// File: rtl/simple_processor.sv
// simple_processor: 16-bit multi-cycle processor with eight general registers.
// One instruction is fetched from iin every four clocks and executed over the
// fixed step sequence T0..T3. The shared internal bus is exported for observation.
module simple_processor (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] iin,
    output logic [15:0] bus
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [3:0] OP_MV  = 4'b0001;
    localparam logic [3:0] OP_MVI = 4'b1010;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1000;

    logic [1:0]  step;
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] g;
    logic [15:0] r [8];

    logic [3:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] imm;
    logic        is_alu;

    assign opcode = ir[15:12];
    assign rx     = ir[11:9];
    assign ry     = ir[8:6];
    assign imm    = {7'd0, ir[8:0]};
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

    // Two-operand ALU; carry and borrow are simply dropped (mod 2^16).
    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] x,
                                        input logic [15:0] y);
        case (op)
            OP_ADD:  alu = x + y;
            OP_SUB:  alu = x - y;
            default: alu = x & y;
        endcase
    endfunction

    // Bus source select: which register or constant drives the bus in this step.
    always_comb begin
        bus = 16'd0;
        if (resetn) begin
            case (step)
                T0: bus = iin;
                T1: begin
                    if (opcode == OP_MV)       bus = r[ry];
                    else if (opcode == OP_OUT) bus = r[rx];
                    else if (opcode == OP_MVI) bus = imm;
                    else if (is_alu)           bus = r[rx];
                end
                T2: if (is_alu) bus = r[ry];
                T3: if (is_alu) bus = g;
                default: bus = 16'd0;
            endcase
        end
    end

    // Step counter, instruction latch and register writes from the bus.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            step <= T0;
            ir   <= 16'd0;
            a    <= 16'd0;
            g    <= 16'd0;
            for (int i = 0; i < 8; i++) r[i] <= 16'd0;
        end else begin
            step <= step + 2'd1;
            case (step)
                T0: ir <= iin;
                T1: begin
                    if (opcode == OP_MV || opcode == OP_MVI) r[rx] <= bus;
                    if (is_alu) a <= bus;
                end
                T2: if (is_alu) g <= alu(opcode, a, bus);
                T3: if (is_alu) r[rx] <= bus;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_processor.sv
// tb_simple_processor: directed scenarios plus randomized instruction stream,
// checked cycle by cycle on the bus against an instruction-level model.
module tb_simple_processor;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] iin    = 16'd0;
    logic [15:0] bus;

    int errors = 0;
    int checks = 0;
    logic [15:0] model_r [8];
    logic [15:0] t1_seen;

    always #5 clock = ~clock;

    simple_processor dut (
        .clock  (clock),
        .resetn (resetn),
        .iin    (iin),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model_r[i] = 16'd0;
    endtask

    // Hold reset for n clocks with random iin; bus must stay 0.
    task automatic do_reset(input int n);
        resetn = 1'b0;
        iin = 16'($urandom);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check("reset_bus", bus, 16'd0);
            iin = 16'($urandom);
            @(posedge clock);
            #1;
        end
        resetn = 1'b1;
        clear_model();
    endtask

    // Execute one instruction (called just after a posedge that starts T0).
    task automatic run_instr(input logic [15:0] ins, input string tag);
        logic [15:0] exp [4];
        logic [3:0]  op;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [15:0] res;
        logic        wr;
        op  = ins[15:12];
        x   = ins[11:9];
        y   = ins[8:6];
        res = 16'd0;
        wr  = 1'b0;
        exp[0] = ins;
        exp[1] = 16'd0;
        exp[2] = 16'd0;
        exp[3] = 16'd0;
        case (op)
            4'b0001: begin exp[1] = model_r[y]; res = model_r[y]; wr = 1'b1; end
            4'b1010: begin exp[1] = {7'd0, ins[8:0]}; res = {7'd0, ins[8:0]}; wr = 1'b1; end
            4'b0010: begin res = model_r[x] + model_r[y]; wr = 1'b1; end
            4'b0011: begin res = model_r[x] - model_r[y]; wr = 1'b1; end
            4'b0100: begin res = model_r[x] & model_r[y]; wr = 1'b1; end
            4'b1000: exp[1] = model_r[x];
            default: ;
        endcase
        if (op == 4'b0010 || op == 4'b0011 || op == 4'b0100) begin
            exp[1] = model_r[x];
            exp[2] = model_r[y];
            exp[3] = res;
        end
        iin = ins;
        for (int s = 0; s < 4; s++) begin
            @(negedge clock);
            if (s == 1) t1_seen = bus;
            check($sformatf("%s_t%0d", tag, s), bus, exp[s]);
            @(posedge clock);
            #1;
        end
        if (wr) model_r[x] = res;
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 8; i++) begin
            run_instr(16'h8000 | (16'(i) << 9), $sformatf("zero_r%0d", i));
            check($sformatf("zero_val_r%0d", i), t1_seen, 16'd0);
        end
    endtask

    initial begin
        logic [3:0] op;
        logic [15:0] ins;
        clear_model();

        // Reset held 4 clocks, then every register reads 0.
        do_reset(4);
        read_all_zero();

        // Directed program from the block description.
        run_instr(16'hA01C, "mvi_r0");
        check("mvi_r0_imm", t1_seen, 16'h001C);
        run_instr(16'hA40A, "mvi_r2");
        run_instr(16'h2080, "add_r0_r2");
        run_instr(16'h8000, "out_r0");
        check("out_r0_val", t1_seen, 16'h0026);
        run_instr(16'hA3FF, "mvi_r1_1ff");
        run_instr(16'h3640, "sub_r3_r1");
        run_instr(16'h8600, "out_r3");
        check("sub_wrap", t1_seen, 16'hFE01);
        run_instr(16'h2240, "add_r1_r1");
        run_instr(16'h8200, "out_r1");
        check("add_double", t1_seen, 16'h03FE);

        // Reset during T2 of an add aborts it.
        run_instr(16'hA205, "mvi_r1_5");
        run_instr(16'hA407, "mvi_r2_7");
        iin = 16'h2280;
        @(negedge clock);
        check("abort_t0", bus, 16'h2280);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("abort_t1", bus, 16'h0005);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        @(negedge clock);
        check("abort_bus", bus, 16'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        clear_model();
        read_all_zero();

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: op = 4'b0001;
                1: op = 4'b1010;
                2: op = 4'b0010;
                3: op = 4'b0011;
                4: op = 4'b0100;
                5: op = 4'b1000;
                default: op = 4'($urandom_range(0, 15));
            endcase
            ins = {op, 12'($urandom)};
            run_instr(ins, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
